// File: rtl/cbp_pkg.sv
// Shared constants and helpers for the pipelined carry-bypass adder.
package cbp_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    function automatic int cbp_block_w(input int num_bits, input int num_stages);
        return num_bits / num_stages;
    endfunction

    // Legal configuration: at least one stage, and the word splits evenly into blocks.
    function automatic bit cbp_cfg_ok(input int num_bits, input int num_stages);
        return (num_stages >= 1) && (num_bits >= num_stages) && ((num_bits % num_stages) == 0);
    endfunction

endpackage

// File: rtl/cbp_block.sv
// One combinational carry-bypass block: ripple adder whose carry-out is bypassed
// straight from carry-in when every bit propagates.
module cbp_block #(
    parameter int BLOCK_W = 8
) (
    input  logic [BLOCK_W-1:0] a,
    input  logic [BLOCK_W-1:0] b,
    input  logic               cin,
    output logic [BLOCK_W-1:0] sum,
    output logic               cout,
    output logic               c_msb_in
);

    logic [BLOCK_W-1:0] prop;
    logic [BLOCK_W-1:0] gen;
    logic               ripple_cout;

    genvar gi;
    for (gi = 0; gi < BLOCK_W; gi++) begin : g_pg
        assign prop[gi] = a[gi] ^ b[gi];
        assign gen[gi]  = a[gi] & b[gi];
    end

    always_comb begin
        logic c_run;
        c_run       = cin;
        c_msb_in    = cin;
        sum         = '0;
        ripple_cout = 1'b0;
        for (int i = 0; i < BLOCK_W; i++) begin
            if (i == BLOCK_W - 1) begin
                c_msb_in = c_run;
            end
            sum[i] = prop[i] ^ c_run;
            c_run  = gen[i] | (prop[i] & c_run);
        end
        ripple_cout = c_run;
    end

    assign cout = (&prop) ? cin : ripple_cout;

endmodule

// File: rtl/pipelined_cbp_adder.sv
// Pipelined carry-bypass adder/subtractor: block k of the word resolves in stage k,
// with a valid/ready handshake that stalls the whole pipe as one unit.
module pipelined_cbp_adder
    import cbp_pkg::*;
#(
    parameter int NUM_BITS   = 32,
    parameter int NUM_STAGES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_BITS-1:0] A,
    input  logic [NUM_BITS-1:0] B,
    input  logic                Cin,
    input  logic                Sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] Sum,
    output logic                Cout,
    output logic                Overflow
);

    localparam int BLOCK_W = cbp_block_w(NUM_BITS, NUM_STAGES);

    if (!cbp_cfg_ok(NUM_BITS, NUM_STAGES)) begin : g_cfg_check
        $error("pipelined_cbp_adder: NUM_BITS must be a non-zero multiple of NUM_STAGES");
    end

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    genvar gi;
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
        localparam int REM_IN = NUM_BITS - gi * BLOCK_W;
        localparam int SUM_W  = (gi + 1) * BLOCK_W;

        logic [REM_IN-1:0]  a_in;
        logic [REM_IN-1:0]  b_in;
        logic               c_in;
        logic               v_in;
        logic [BLOCK_W-1:0] blk_sum;
        logic               blk_cout;
        logic               blk_cmsb;
        logic [SUM_W-1:0]   sum_d;
        logic [SUM_W-1:0]   sum_q;
        logic               c_q;
        logic               v_q;

        if (gi == 0) begin : g_src
            assign a_in  = A;
            assign b_in  = (Sub == ADD) ? B : ~B;
            assign c_in  = (Sub == SUB) ? 1'b1 : Cin;
            assign v_in  = in_valid;
            assign sum_d = blk_sum;
        end else begin : g_src
            assign a_in  = g_stage[gi-1].g_mid.a_q;
            assign b_in  = g_stage[gi-1].g_mid.b_q;
            assign c_in  = g_stage[gi-1].c_q;
            assign v_in  = g_stage[gi-1].v_q;
            assign sum_d = {blk_sum, g_stage[gi-1].sum_q};
        end

        cbp_block #(
            .BLOCK_W (BLOCK_W)
        ) u_block (
            .a        (a_in[BLOCK_W-1:0]),
            .b        (b_in[BLOCK_W-1:0]),
            .cin      (c_in),
            .sum      (blk_sum),
            .cout     (blk_cout),
            .c_msb_in (blk_cmsb)
        );

        if (gi < NUM_STAGES - 1) begin : g_mid
            // Operand bits not yet consumed travel with the beat to later stages.
            logic [REM_IN-BLOCK_W-1:0] a_q;
            logic [REM_IN-BLOCK_W-1:0] b_q;
            logic                      unused_cmsb;

            // Only the top block's MSB carry matters, for signed overflow.
            assign unused_cmsb = blk_cmsb;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q   <= 1'b0;
                    c_q   <= 1'b0;
                    sum_q <= '0;
                    a_q   <= '0;
                    b_q   <= '0;
                end else if (adv) begin
                    v_q   <= v_in;
                    c_q   <= blk_cout;
                    sum_q <= sum_d;
                    a_q   <= a_in[REM_IN-1:BLOCK_W];
                    b_q   <= b_in[REM_IN-1:BLOCK_W];
                end
            end
        end else begin : g_last
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q   <= 1'b0;
                    c_q   <= 1'b0;
                    sum_q <= '0;
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    v_q   <= v_in;
                    c_q   <= blk_cout;
                    sum_q <= sum_d;
                    ovf_q <= blk_cmsb ^ blk_cout;
                end
            end
        end
    end

    assign out_valid = g_stage[NUM_STAGES-1].v_q;
    assign Sum       = g_stage[NUM_STAGES-1].sum_q;
    assign Cout      = g_stage[NUM_STAGES-1].c_q;
    assign Overflow  = g_stage[NUM_STAGES-1].g_last.ovf_q;

endmodule
